// File: rtl/floppy_pkg.sv
// Shared constants for the floppy/SD datapath: SPI master state encoding and
// default SCLK divisors.
package floppy_pkg;

  typedef enum logic {
    SPI_IDLE  = 1'b0,
    SPI_SHIFT = 1'b1
  } spi_state_e;

  localparam int SPI_DIV_DEF      = 2;
  localparam int SPI_DIV_SLOW_DEF = 64;

endpackage

// File: rtl/spi_byte_master_if.sv
// Byte-level handshake between the DMA block (master) and the SPI byte master
// (slave). The received-byte port is called dout because "do" is a keyword.
interface spi_byte_master_if;
  logic [7:0] di;
  logic       wr;
  logic [7:0] dout;
  logic       dsr;
  logic       slow;
  logic       cs_wr;
  logic       cs_val;

  modport master (output di, wr, slow, cs_wr, cs_val, input dout, dsr);
  modport slave  (input di, wr, slow, cs_wr, cs_val, output dout, dsr);
endinterface

// File: rtl/spi_clk_div.sv
// SCLK half-period divider: latches the divisor at byte start and emits a
// one-cycle toggle pulse every divisor ce edges while running.
module spi_clk_div
  import floppy_pkg::*;
#(
  parameter int DIV      = SPI_DIV_DEF,
  parameter int DIV_SLOW = SPI_DIV_SLOW_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ce,
  input  logic load,
  input  logic slow,
  input  logic run,
  output logic tick
);

  localparam logic [7:0] DIV_F = 8'(DIV);
  localparam logic [7:0] DIV_S = 8'(DIV_SLOW);

  logic [7:0] divisor;
  logic [7:0] divctr;
  logic [7:0] div_sel;

  assign div_sel = slow ? DIV_S : DIV_F;
  assign tick    = ce & run & (divctr == 8'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      divisor <= DIV_F;
      divctr  <= '0;
    end else if (ce) begin
      if (load) begin
        divisor <= div_sel;
        divctr  <= div_sel - 8'd1;
      end else if (run) begin
        divctr <= (divctr == 8'd0) ? divisor - 8'd1 : divctr - 8'd1;
      end
    end
  end

endmodule

// File: rtl/spi_byte_master.sv
// Mode-0 MSB-first byte SPI master with chip-select register and slow/fast
// SCLK selection, fed by the floppy DMA block.
module spi_byte_master
  import floppy_pkg::*;
#(
  parameter int DIV      = SPI_DIV_DEF,
  parameter int DIV_SLOW = SPI_DIV_SLOW_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ce,
  spi_byte_master_if.slave   bus,
  output logic               sclk,
  output logic               mosi,
  input  logic               miso,
  output logic               cs_n
);

  spi_state_e state;
  logic [7:0] shreg;
  logic [7:0] rx;
  logic [7:0] dout_r;
  logic [3:0] edgectr;
  logic       dsr_r;
  logic       tick;
  logic       start;

  assign start    = (state == SPI_IDLE) & bus.wr;
  // Drop ready in the very cycle wr is raised so upstream never sees a stale flag.
  assign bus.dsr  = dsr_r & ~bus.wr;
  assign bus.dout = dout_r;

  spi_clk_div #(.DIV(DIV), .DIV_SLOW(DIV_SLOW)) u_div (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (ce),
    .load    (start),
    .slow    (bus.slow),
    .run     (state == SPI_SHIFT),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= SPI_IDLE;
      sclk    <= 1'b0;
      mosi    <= 1'b1;
      cs_n    <= 1'b1;
      dout_r  <= 8'hFF;
      dsr_r   <= 1'b1;
      shreg   <= 8'hFF;
      rx      <= '0;
      edgectr <= '0;
    end else if (ce) begin
      if (bus.cs_wr) cs_n <= bus.cs_val;
      case (state)
        SPI_IDLE: begin
          if (bus.wr) begin
            shreg   <= bus.di;
            mosi    <= bus.di[7];
            dsr_r   <= 1'b0;
            edgectr <= 4'd15;
            state   <= SPI_SHIFT;
          end
        end
        SPI_SHIFT: begin
          if (tick) begin
            sclk <= ~sclk;
            if (!sclk) begin
              rx <= {rx[6:0], miso};
            end else begin
              shreg <= {shreg[6:0], 1'b1};
              mosi  <= shreg[6];
              // 16th toggle: all 8 samples are already in rx
              if (edgectr == 4'd0) begin
                dout_r <= rx;
                dsr_r  <= 1'b1;
                mosi   <= 1'b1;
                state  <= SPI_IDLE;
              end
            end
            if (edgectr != 4'd0) edgectr <= edgectr - 4'd1;
          end
        end
        default: state <= SPI_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_byte_master.sv
// Self-checking bench: randomized bytes against an SPI slave/loopback model
// with timing derived from 16 half-periods per byte.
module tb_spi_byte_master;
  import floppy_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  logic ce;
  logic sclk, mosi, miso, cs_n;

  spi_byte_master_if bus();

  spi_byte_master #(.DIV(2), .DIV_SLOW(64)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (ce),
    .bus     (bus),
    .sclk    (sclk),
    .mosi    (mosi),
    .miso    (miso),
    .cs_n    (cs_n)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int ce_div = 1;
  int ce_cnt = 0;

  // SPI bus observers and slave model
  logic   loop_mode = 1'b1;
  logic [7:0] slv_byte = 8'hFF;
  int     slv_base = 0;
  int     fall_tot = 0;
  int     edge_cnt = 0;
  int     dsr_rises = 0;
  int     slv_idx;
  logic   rise_q[$];
  longint rise_t[$];

  always @(posedge sclk) begin
    rise_q.push_back(mosi);
    rise_t.push_back($time);
  end
  always @(negedge sclk) fall_tot++;
  always @(sclk) edge_cnt++;
  always @(posedge bus.dsr) dsr_rises++;

  assign slv_idx = fall_tot - slv_base;
  assign miso = loop_mode ? mosi : ((slv_idx >= 0 && slv_idx < 8) ? slv_byte[7 - slv_idx] : 1'b1);

  function automatic int exp_cycles(input logic sl, input int cdiv);
    return 16 * (sl ? 64 : 2) * cdiv;
  endfunction

  function automatic logic [7:0] bits_from(input int base);
    logic [7:0] b = 8'hFF;
    for (int i = 0; i < 8; i++)
      if (base + i < rise_q.size()) b[7 - i] = rise_q[base + i];
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    ce_cnt++;
    ce = (ce_div == 1) || (ce_cnt % ce_div == 0);
  endtask

  task automatic xfer(input logic [7:0] d, input logic sl, input int lim, output int n);
    while (!ce) step();
    bus.di = d; bus.slow = sl; bus.wr = 1'b1;
    #1;
    n_chk++;
    if (bus.dsr !== 1'b0) begin
      n_fail++; $display("FAIL dsr_low_in_wr_cycle: got %b want 0", bus.dsr);
    end
    step();
    bus.wr = 1'b0;
    n = 0;
    while (bus.dsr !== 1'b1 && n < lim) begin step(); n++; end
  endtask

  task automatic test_reset();
    int e0, k;
    reset_n = 1'b0; ce = 1'b1;
    bus.wr = 1'b0; bus.di = 8'h00; bus.slow = 1'b0; bus.cs_wr = 1'b0; bus.cs_val = 1'b1;
    repeat (3) step();
    n_chk += 5;
    if (sclk !== 1'b0)       begin n_fail++; $display("FAIL rst_sclk: got %b want 0", sclk); end
    if (mosi !== 1'b1)       begin n_fail++; $display("FAIL rst_mosi: got %b want 1", mosi); end
    if (cs_n !== 1'b1)       begin n_fail++; $display("FAIL rst_cs_n: got %b want 1", cs_n); end
    if (bus.dsr !== 1'b1)    begin n_fail++; $display("FAIL rst_dsr: got %b want 1", bus.dsr); end
    if (bus.dout !== 8'hFF)  begin n_fail++; $display("FAIL rst_dout: got %h want ff", bus.dout); end
    reset_n = 1'b1;
    step();
    bus.cs_wr = 1'b1; bus.cs_val = 1'b0;
    step();
    bus.cs_wr = 1'b0; bus.cs_val = 1'b1;
    e0 = edge_cnt;
    loop_mode = 1'b1;
    bus.di = 8'h5A; bus.wr = 1'b1;
    step();
    bus.wr = 1'b0;
    k = 0;
    while (edge_cnt - e0 < 5 && k < 100) begin step(); k++; end
    n_chk++;
    if (edge_cnt - e0 != 5) begin n_fail++; $display("FAIL rst_mid_edges: got %0d want 5", edge_cnt - e0); end
    #2 reset_n = 1'b0;
    #1;
    n_chk += 5;
    if (sclk !== 1'b0)       begin n_fail++; $display("FAIL midrst_sclk: got %b want 0", sclk); end
    if (mosi !== 1'b1)       begin n_fail++; $display("FAIL midrst_mosi: got %b want 1", mosi); end
    if (cs_n !== 1'b1)       begin n_fail++; $display("FAIL midrst_cs_n: got %b want 1", cs_n); end
    if (bus.dsr !== 1'b1)    begin n_fail++; $display("FAIL midrst_dsr: got %b want 1", bus.dsr); end
    if (bus.dout !== 8'hFF)  begin n_fail++; $display("FAIL midrst_dout: got %h want ff", bus.dout); end
    repeat (2) step();
    reset_n = 1'b1;
    e0 = edge_cnt;
    repeat (40) step();
    n_chk += 2;
    if (edge_cnt != e0)      begin n_fail++; $display("FAIL postrst_sclk_quiet: got %0d edges want 0", edge_cnt - e0); end
    if (bus.dout !== 8'hFF)  begin n_fail++; $display("FAIL postrst_dout: got %h want ff", bus.dout); end
  endtask

  task automatic test_cs();
    bus.cs_val = 1'b0; bus.cs_wr = 1'b1;
    #1;
    n_chk++;
    if (cs_n !== 1'b1) begin n_fail++; $display("FAIL cs_before_edge: got %b want 1", cs_n); end
    step();
    bus.cs_wr = 1'b0;
    n_chk++;
    if (cs_n !== 1'b0) begin n_fail++; $display("FAIL cs_low: got %b want 0", cs_n); end
    bus.cs_val = 1'b1; bus.cs_wr = 1'b1;
    step();
    bus.cs_wr = 1'b0;
    n_chk++;
    if (cs_n !== 1'b1) begin n_fail++; $display("FAIL cs_high: got %b want 1", cs_n); end
  endtask

  task automatic test_loopback();
    int n, rb;
    loop_mode = 1'b1;
    rb = rise_q.size();
    xfer(8'hA5, 1'b0, 200, n);
    n_chk += 6;
    if (n != exp_cycles(1'b0, 1))       begin n_fail++; $display("FAIL lb_latency: got %0d want %0d", n, exp_cycles(1'b0, 1)); end
    if (rise_q.size() - rb != 8)        begin n_fail++; $display("FAIL lb_rises: got %0d want 8", rise_q.size() - rb); end
    if (bits_from(rb) !== 8'hA5)        begin n_fail++; $display("FAIL lb_mosi_bits: got %h want a5", bits_from(rb)); end
    if (bus.dout !== 8'hA5)             begin n_fail++; $display("FAIL lb_dout: got %h want a5", bus.dout); end
    if (sclk !== 1'b0)                  begin n_fail++; $display("FAIL lb_sclk_idle: got %b want 0", sclk); end
    if (mosi !== 1'b1)                  begin n_fail++; $display("FAIL lb_mosi_idle: got %b want 1", mosi); end
  endtask

  task automatic test_slave();
    int n, rb;
    loop_mode = 1'b0;
    slv_byte = 8'h3C; slv_base = fall_tot;
    rb = rise_q.size();
    xfer(8'hFF, 1'b0, 200, n);
    n_chk += 3;
    if (bus.dout !== 8'h3C)   begin n_fail++; $display("FAIL slv_dout: got %h want 3c", bus.dout); end
    if (bits_from(rb) !== 8'hFF || rise_q.size() - rb != 8)
                              begin n_fail++; $display("FAIL slv_mosi_ones: got %h want ff", bits_from(rb)); end
    if (n != 32)              begin n_fail++; $display("FAIL slv_latency: got %0d want 32", n); end
  endtask

  task automatic test_slow();
    int n, rb;
    logic [7:0] d, s;
    loop_mode = 1'b0;
    d = 8'($urandom); s = 8'($urandom);
    slv_byte = s; slv_base = fall_tot;
    rb = rise_q.size();
    xfer(d, 1'b1, 3000, n);
    n_chk += 4;
    if (n != exp_cycles(1'b1, 1)) begin n_fail++; $display("FAIL slow_latency: got %0d want %0d", n, exp_cycles(1'b1, 1)); end
    if (bus.dout !== s)           begin n_fail++; $display("FAIL slow_dout: got %h want %h", bus.dout, s); end
    if (bits_from(rb) !== d)      begin n_fail++; $display("FAIL slow_mosi: got %h want %h", bits_from(rb), d); end
    if (rise_t.size() < rb + 2 || rise_t[rb + 1] - rise_t[rb] != 64'd1280)
                                  begin n_fail++; $display("FAIL slow_period: got %0d want 1280", (rise_t.size() >= rb + 2) ? rise_t[rb + 1] - rise_t[rb] : 0); end
    d = 8'($urandom); s = 8'($urandom);
    slv_byte = s; slv_base = fall_tot;
    xfer(d, 1'b0, 3000, n);
    n_chk += 2;
    if (n != 32)                  begin n_fail++; $display("FAIL fast_after_slow_latency: got %0d want 32", n); end
    if (bus.dout !== s)           begin n_fail++; $display("FAIL fast_after_slow_dout: got %h want %h", bus.dout, s); end
  endtask

  task automatic test_ce_gating();
    int n, rb, e0;
    logic [7:0] d, prev;
    loop_mode = 1'b1;
    ce_div = 3; ce_cnt = 0;
    step();
    prev = bus.dout;
    while (ce) step();
    e0 = edge_cnt;
    bus.di = 8'h00; bus.wr = 1'b1;
    step();
    bus.wr = 1'b0;
    repeat (12) step();
    n_chk += 3;
    if (edge_cnt != e0)   begin n_fail++; $display("FAIL ce0_wr_ignored_sclk: got %0d edges want 0", edge_cnt - e0); end
    if (bus.dsr !== 1'b1) begin n_fail++; $display("FAIL ce0_wr_ignored_dsr: got %b want 1", bus.dsr); end
    if (bus.dout !== prev) begin n_fail++; $display("FAIL ce0_wr_ignored_dout: got %h want %h", bus.dout, prev); end
    d = 8'($urandom);
    rb = rise_q.size();
    xfer(d, 1'b0, 400, n);
    n_chk += 3;
    if (n != exp_cycles(1'b0, 3)) begin n_fail++; $display("FAIL ce3_latency: got %0d want %0d", n, exp_cycles(1'b0, 3)); end
    if (bus.dout !== d)           begin n_fail++; $display("FAIL ce3_dout: got %h want %h", bus.dout, d); end
    if (rise_t.size() < rb + 2 || rise_t[rb + 1] - rise_t[rb] != 64'd120)
                                  begin n_fail++; $display("FAIL ce3_period: got %0d want 120", (rise_t.size() >= rb + 2) ? rise_t[rb + 1] - rise_t[rb] : 0); end
    ce_div = 1; ce = 1'b1;
  endtask

  task automatic test_back_to_back();
    int n, rb, e0, base_r;
    logic [7:0] d, s, got;
    loop_mode = 1'b1;
    // wr re-pulsed mid-byte must be ignored
    d = 8'($urandom);
    rb = rise_q.size();
    bus.di = d; bus.wr = 1'b1;
    step();
    bus.wr = 1'b0;
    repeat (10) step();
    bus.di = ~d; bus.wr = 1'b1;
    step();
    bus.wr = 1'b0;
    n_chk++;
    if (bus.dsr !== 1'b0) begin n_fail++; $display("FAIL midwr_dsr: got %b want 0", bus.dsr); end
    n = 11;
    while (bus.dsr !== 1'b1 && n < 200) begin step(); n++; end
    n_chk += 3;
    if (n != 32)                 begin n_fail++; $display("FAIL midwr_latency: got %0d want 32", n); end
    if (bus.dout !== d)          begin n_fail++; $display("FAIL midwr_dout: got %h want %h", bus.dout, d); end
    if (rise_q.size() - rb != 8) begin n_fail++; $display("FAIL midwr_rises: got %0d want 8", rise_q.size() - rb); end
    // wr held on the completing edge is not accepted
    d = 8'($urandom);
    bus.di = d; bus.wr = 1'b1;
    step();
    bus.wr = 1'b0;
    repeat (31) step();
    n_chk++;
    if (bus.dsr !== 1'b0) begin n_fail++; $display("FAIL edge31_busy: got %b want 0", bus.dsr); end
    bus.di = ~d; bus.wr = 1'b1;
    step();
    bus.wr = 1'b0;
    #1;
    e0 = edge_cnt;
    n_chk += 2;
    if (bus.dout !== d)   begin n_fail++; $display("FAIL done_edge_dout: got %h want %h", bus.dout, d); end
    if (bus.dsr !== 1'b1) begin n_fail++; $display("FAIL done_edge_dsr: got %b want 1", bus.dsr); end
    repeat (8) step();
    n_chk++;
    if (edge_cnt != e0 || bus.dsr !== 1'b1)
      begin n_fail++; $display("FAIL done_edge_wr_ignored: got %0d edges dsr %b want 0 edges dsr 1", edge_cnt - e0, bus.dsr); end
    // DMA-style stream of random bytes against the slave model
    loop_mode = 1'b0;
    base_r = dsr_rises;
    for (int i = 0; i < 512; i++) begin
      d = 8'($urandom); s = 8'($urandom);
      slv_byte = s; slv_base = fall_tot;
      rb = rise_q.size();
      xfer(d, 1'b0, 100, n);
      got = bits_from(rb);
      n_chk += 3;
      if (bus.dout !== s) begin n_fail++; $display("FAIL dma_dout[%0d]: got %h want %h", i, bus.dout, s); end
      if (got !== d)      begin n_fail++; $display("FAIL dma_mosi[%0d]: got %h want %h", i, got, d); end
      if (n != 32)        begin n_fail++; $display("FAIL dma_latency[%0d]: got %0d want 32", i, n); end
    end
    n_chk++;
    if (dsr_rises - base_r != 512) begin n_fail++; $display("FAIL dma_dsr_rises: got %0d want 512", dsr_rises - base_r); end
  endtask

  initial begin
    test_reset();
    test_cs();
    test_loopback();
    test_slave();
    test_slow();
    test_ce_gating();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
